// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode patterns, class/state enums and trap causes for the ARM-lite control path
package cpu_pkg;

  // Opcode bits [31:21]; '?' marks bits that are don't-care for decode.
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b000101?????;
  localparam logic [10:0] OP_BLT  = 11'b01010100???;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;

  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BR, C_ILLEGAL} op_class_t;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  typedef enum logic [1:0] {BR_NONE, BR_B, BR_LT, BR_CBZ} br_kind_t;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_IMEM    = 2'b10;
  localparam logic [1:0] TC_DMEM    = 2'b11;

endpackage

// File: rtl/opcode_classify.sv
// rtl/opcode_classify.sv - combinational opcode class, flag-setting and branch-kind decode
module opcode_classify
  import cpu_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class,
  output logic        is_flagset,
  output br_kind_t    br_kind
);

  // Map the instruction register opcode field onto its execution class.
  always_comb begin
    op_class   = C_ILLEGAL;
    is_flagset = 1'b0;
    br_kind    = BR_NONE;
    casez (opcode)
      OP_ADDI, OP_AND, OP_EOR, OP_LSR: op_class = C_ALU;
      OP_ADDS, OP_SUBS: begin
        op_class   = C_ALU;
        is_flagset = 1'b1;
      end
      OP_LDUR: op_class = C_LOAD;
      OP_STUR: op_class = C_STORE;
      OP_B: begin
        op_class = C_BR;
        br_kind  = BR_B;
      end
      OP_BLT: begin
        op_class = C_BR;
        br_kind  = BR_LT;
      end
      OP_CBZ: begin
        op_class = C_BR;
        br_kind  = BR_CBZ;
      end
      default: op_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle fetch/decode/exec/mem/writeback control FSM with memory timeouts and traps
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             flag_n,
  input  logic             flag_v,
  input  logic             rt_zero,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             rf_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             flag_we,
  output logic             instr_done,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timed_out;
  logic              trap_r;
  logic [1:0]        cause_r, cause_next;
  op_class_t         op_class;
  logic              is_flagset;
  br_kind_t          br_kind;

  opcode_classify u_classify (
    .opcode    (opcode),
    .op_class  (op_class),
    .is_flagset(is_flagset),
    .br_kind   (br_kind)
  );

  // A ready on the timeout cycle still wins because ready is tested first below.
  assign timed_out  = (wait_cnt == TIMEOUT_VAL);
  assign trap       = trap_r;
  assign trap_cause = cause_r;

  // Next-state and strobe decode; strobes are forced low while reset is held.
  always_comb begin
    state_next    = state;
    cause_next    = cause_r;
    waiting       = 1'b0;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    rf_we         = 1'b0;
    dmem_re       = 1'b0;
    dmem_we       = 1'b0;
    flag_we       = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = TC_IMEM;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_class == C_ILLEGAL) begin
          state_next = S_TRAP;
          cause_next = TC_ILLEGAL;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_class)
          C_ALU: begin
            flag_we    = is_flagset;
            state_next = S_WB;
          end
          C_LOAD, C_STORE: state_next = S_MEM;
          C_BR: begin
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
            case (br_kind)
              BR_B:    pc_sel_branch = 1'b1;
              BR_LT:   pc_sel_branch = flag_n ^ flag_v;
              BR_CBZ:  pc_sel_branch = rt_zero;
              default: pc_sel_branch = 1'b0;
            endcase
          end
          default: begin
            state_next = S_TRAP;
            cause_next = TC_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (op_class == C_LOAD) dmem_re = 1'b1;
        else                    dmem_we = 1'b1;
        if (dmem_ready) begin
          if (op_class == C_LOAD) begin
            state_next = S_WB;
          end else begin
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = TC_DMEM;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    if (reset) begin
      imem_req      = 1'b0;
      ir_load       = 1'b0;
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
      rf_we         = 1'b0;
      dmem_re       = 1'b0;
      dmem_we       = 1'b0;
      flag_we       = 1'b0;
      instr_done    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Wait counter restarts on every state change and counts stalled request cycles.
  always_ff @(posedge clk) begin
    if (reset || (state_next != state)) wait_cnt <= '0;
    else if (waiting)                   wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky trap flag and cause; the cause only moves on entry into TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_r  <= 1'b0;
      cause_r <= TC_NONE;
    end else begin
      if (state_next == S_TRAP) trap_r <= 1'b1;
      cause_r <= cause_next;
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (reset)           instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 32;

  localparam int K_ADDI = 0, K_ADDS = 1, K_AND = 2, K_EOR = 3, K_LSR = 4, K_SUBS = 5;
  localparam int K_LDUR = 6, K_STUR = 7, K_B = 8, K_BLT = 9, K_CBZ = 10, K_ILL = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   opcode = '0;
  logic          imem_ready = 1'b0, dmem_ready = 1'b0;
  logic          flag_n = 1'b0, flag_v = 1'b0, rt_zero = 1'b0;
  logic          imem_req, ir_load, pc_en, pc_sel_branch, rf_we;
  logic          dmem_re, dmem_we, flag_we, instr_done, trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instr_count;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned exp_count = 0;
  logic m_n = 1'b0, m_v = 1'b0;

  multicycle_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .flag_n(flag_n), .flag_v(flag_v), .rt_zero(rt_zero),
    .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .rf_we(rf_we), .dmem_re(dmem_re), .dmem_we(dmem_we), .flag_we(flag_we),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] strobes();
    return {imem_req, ir_load, pc_en, pc_sel_branch, rf_we, dmem_re, dmem_we, flag_we, instr_done};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] make_op(input int kind);
    logic [10:0] r;
    r = 11'($urandom);
    case (kind)
      K_ADDI:  return {10'b1001000100, r[0]};
      K_ADDS:  return 11'b10101011000;
      K_AND:   return 11'b10001010000;
      K_EOR:   return 11'b11001010000;
      K_LSR:   return 11'b11010011010;
      K_SUBS:  return 11'b11101011000;
      K_LDUR:  return 11'b11111000010;
      K_STUR:  return 11'b11111000000;
      K_B:     return {6'b000101, r[4:0]};
      K_BLT:   return {8'b01010100, r[2:0]};
      K_CBZ:   return {8'b10110100, r[2:0]};
      default: return 11'b11111111111;
    endcase
  endfunction

  function automatic int base_cycles(input int kind);
    if (kind >= K_B)     return 3;
    if (kind == K_LDUR)  return 5;
    return 4;
  endfunction

  // Reset for a few cycles, then leave the bench inside the first cycle after release.
  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("strobes_in_reset", strobes(), 9'd0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b1);
    check("rst_other_strobes", strobes() & 9'h0FF, 9'd0);
    check("rst_trap", trap, 1'b0);
    check("rst_cause", trap_cause, 2'b00);
    check("rst_count", instr_count, 0);
    exp_count = 0;
  endtask

  // Run one non-trapping instruction with a behavioural memory and compare against the model.
  task automatic run_instr(input int kind, input int iw, input int dw,
                           input logic nn, input logic nv, input logic rz);
    int cyc = 0, ireq = 0, dreq = 0, n_fw = 0, fw_at = 0, n_rf = 0, rf_at = 0;
    int n_dre = 0, n_dwe = 0, n_pc = 0;
    logic sel = 1'b0, done = 1'b0, pend = 1'b0;
    bit is_mem, flagset, writes_rf;
    int exp_cyc;
    logic exp_sel;
    is_mem    = (kind == K_LDUR) || (kind == K_STUR);
    flagset   = (kind == K_ADDS) || (kind == K_SUBS);
    writes_rf = (kind <= K_LDUR);
    exp_cyc   = base_cycles(kind) + iw + (is_mem ? dw : 0);
    exp_sel   = (kind == K_B) ? 1'b1 : (kind == K_BLT) ? (m_n ^ m_v) : (kind == K_CBZ) ? rz : 1'b0;
    opcode  = make_op(kind);
    rt_zero = rz;
    while (!done && cyc < 60) begin
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      if (imem_req) begin
        if (ireq == iw) imem_ready = 1'b1;
        ireq++;
      end
      if (dmem_re || dmem_we) begin
        if (dreq == dw) dmem_ready = 1'b1;
        dreq++;
      end
      #1;
      cyc++;
      if (flag_we) begin n_fw++; fw_at = cyc; pend = 1'b1; end
      if (rf_we) begin n_rf++; rf_at = cyc; end
      if (dmem_re) n_dre++;
      if (dmem_we) n_dwe++;
      if (pc_en) begin n_pc++; sel = pc_sel_branch; end
      if (instr_done) done = 1'b1;
      @(negedge clk);
      if (pend) begin flag_n = nn; flag_v = nv; pend = 1'b0; end
    end
    check($sformatf("done_k%0d", kind), done, 1'b1);
    check($sformatf("cycles_k%0d_iw%0d_dw%0d", kind, iw, dw), cyc, exp_cyc);
    check($sformatf("flag_we_k%0d", kind), n_fw, flagset ? 1 : 0);
    if (flagset) check("flag_we_in_exec", fw_at, iw + 3);
    check($sformatf("rf_we_k%0d", kind), n_rf, writes_rf ? 1 : 0);
    if (writes_rf) check("rf_we_last_cycle", rf_at, exp_cyc);
    check($sformatf("dmem_re_k%0d", kind), n_dre, (kind == K_LDUR) ? dw + 1 : 0);
    check($sformatf("dmem_we_k%0d", kind), n_dwe, (kind == K_STUR) ? dw + 1 : 0);
    check($sformatf("pc_en_k%0d", kind), n_pc, 1);
    check($sformatf("pc_sel_k%0d", kind), sel, exp_sel);
    exp_count++;
    if (flagset) begin m_n = nn; m_v = nv; end
    #1;
    check("instr_count", instr_count, exp_count);
    check("no_trap", trap, 1'b0);
  endtask

  // Drive until a trap appears; check when and why, then that the core stays dead.
  task automatic run_to_trap(input int kind, input logic iready, input int exp_idx,
                             input logic [1:0] exp_cause, input string tag);
    int idx = -1;
    logic [8:0] seen = '0;
    opcode = make_op(kind);
    for (int c = 0; c < 30 && idx < 0; c++) begin
      imem_ready = iready;
      dmem_ready = 1'b0;
      #1;
      if (trap) idx = c;
      else @(negedge clk);
    end
    check({tag, "_trap_cycle"}, idx, exp_idx);
    check({tag, "_cause"}, trap_cause, exp_cause);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      #1;
      seen = seen | strobes();
    end
    check({tag, "_dead_strobes"}, seen, 9'd0);
    check({tag, "_trap_sticky"}, {trap, trap_cause}, {1'b1, exp_cause});
    check({tag, "_count_frozen"}, instr_count, exp_count);
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Zero-wait stream; ADDS leaves N=1,V=0 so B.LT is taken.
    run_instr(K_ADDS, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_LDUR, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_STUR, 0, 0, 1'b0, 1'b0, 1'b0);

    // Load with three data wait cycles, then CBZ not-taken and taken.
    run_instr(K_LDUR, 0, 3, 1'b0, 1'b0, 1'b0);
    run_instr(K_CBZ, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_CBZ, 0, 0, 1'b0, 1'b0, 1'b1);

    // Random legal stream, waits up to and including the timeout boundary.
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 10), $urandom_range(0, TO), $urandom_range(0, TO),
                1'($urandom), 1'($urandom), 1'($urandom));

    // Illegal opcode traps after DECODE with the retired count frozen.
    run_to_trap(K_ILL, 1'b1, 2, 2'b01, "illegal");

    // Instruction memory never answers.
    do_reset();
    run_to_trap(K_ADDI, 1'b0, TO + 1, 2'b10, "imem_timeout");

    // Ready on the timeout cycle itself wins.
    do_reset();
    run_instr(K_ADDI, TO, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_STUR, 0, TO, 1'b0, 1'b0, 1'b0);

    // Data memory never answers a load.
    do_reset();
    run_to_trap(K_LDUR, 1'b1, TO + 4, 2'b11, "dmem_timeout");

    // Reset while a store sits in MEM.
    do_reset();
    run_instr(K_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
    opcode = make_op(K_STUR);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    check("stur_mem_dmem_we", dmem_we, 1'b1);
    reset = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check("reset_mid_dmem_we", dmem_we, 1'b0);
    check("reset_mid_done", instr_done, 1'b0);
    check("reset_mid_pc_en", pc_en, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dmem_ready = 1'b0;
    #1;
    check("after_reset_imem_req", imem_req, 1'b1);
    check("after_reset_dmem_we", dmem_we, 1'b0);
    check("after_reset_count", instr_count, 0);
    exp_count = 0;
    run_instr(K_EOR, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control FSM for the ARM-lite CPU. It steps each instruction through fetch, decode, execute, memory and writeback over several cycles, handshaking with instruction and data memory that can insert wait states. It sits beside the datapath in place of a single-cycle control path and drives its load, write and PC enables. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- MEM_TIMEOUT, 255, maximum wait cycles on any memory handshake before trapping
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- opcode  in  11  instruction bits [31:21] from the instruction register; valid from DECODE onward
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory read data valid or write accepted this cycle
- flag_n, flag_v  in  1 each  registered N and V flags
- rt_zero  in  1  the register read for CBZ is zero
- imem_req  out  1  instruction fetch request
- ir_load  out  1  capture instruction memory data into the instruction register
- pc_en  out  1  update PC this cycle
- pc_sel_branch  out  1  1 selects the branch target, 0 selects PC+4; meaningful only when pc_en=1
- rf_we  out  1  register file write
- dmem_re, dmem_we  out  1 each  data memory read or write request
- flag_we  out  1  load the flags register from the ALU
- instr_done  out  1  one-cycle pulse when an instruction retires
- trap  out  1  sticky error indication
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
- instr_count  out  CNT_W  retired-instruction count

## Operation
- Opcode classes are decoded with casez:
  - ALU: ADDI 1001000100x, ADDS 10101011000, AND 10001010000, EOR 11001010000, LSR 11010011010, SUBS 11101011000
  - LOAD: LDUR 11111000010
  - STORE: STUR 11111000000
  - BR: B 000101xxxxx, B.LT 01010100xxx, CBZ 10110100xxx
  - Any other value is ILLEGAL.
- FETCH: imem_req=1.
  - When imem_ready=1: ir_load=1, go to DECODE.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT: go to TRAP, cause 10.
- DECODE: one cycle for the register read. ILLEGAL goes to TRAP with cause 01; every other class goes to EXEC.
- EXEC:
  - ALU: flag_we=1 only for ADDS and SUBS; go to WB.
  - LOAD and STORE: go to MEM.
  - BR: pc_en=1, instr_done=1, go to FETCH.
    - pc_sel_branch=1 for B.
    - pc_sel_branch=(flag_n^flag_v) for B.LT.
    - pc_sel_branch=rt_zero for CBZ.
- MEM: assert dmem_re for LOAD or dmem_we for STORE; hold it until dmem_ready=1.
  - On dmem_ready=1, LOAD goes to WB.
  - On dmem_ready=1, STORE asserts pc_en=1, pc_sel_branch=0, instr_done=1 and goes to FETCH.
  - Timeout goes to TRAP with cause 11.
- WB: rf_we=1, pc_en=1, pc_sel_branch=0, instr_done=1, go to FETCH.
- TRAP: absorbing until reset.
  - trap=1 and trap_cause holds its value.
  - All enables and requests are 0; instr_count freezes.
- instr_count increments on every instr_done and wraps modulo 2^CNT_W.
- The wait counter clears on every state change and on reset.

## Timing
- Reset state:
  - State is FETCH and instr_count=0.
  - trap=0 and trap_cause=00.
  - All strobes are 0 during reset and on the first cycle after it, except imem_req, which rises on the first cycle after reset.
- Outputs are Moore/Mealy combinational from the state and the current-cycle ready and flag inputs. There are no registered output delays.
- Cycles per instruction with zero-wait memory (ready on the first request cycle): BR 3, ALU 4, STORE 4, LOAD 5. Each memory wait cycle adds 1.
- Requests stay asserted continuously until their ready arrives. A ready arriving outside a request state is ignored.
- Timeout triggers on the cycle in which the wait count equals MEM_TIMEOUT with ready still 0. A ready arriving on that same cycle wins, and no trap is raised.
- Branch flags are sampled during EXEC. For the following instruction's branch, flags written by an ADDS/SUBS are already visible.
- Reset mid-instruction: abandon the instruction immediately. No rf_we, dmem_we or instr_done is issued on the reset cycle.

## Structure
- Package cpu_pkg holds:
  - the opcode casez constants shared with the single-cycle control path
  - the class enum {C_ALU, C_LOAD, C_STORE, C_BR, C_ILLEGAL}
  - the state enum {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP}
  - the trap-cause constants
- Sub-module opcode_classify is purely combinational: opcode in, class plus the is_flagset and branch-kind outputs.
- Top level: state register, wait counter, instr_count, trap registers, output decode.

## Test plan
- Zero-wait stream ADDS, B.LT, LDUR, STUR, with the ADDS producing N=1, V=0:
  - ADDS: 4 cycles, flag_we pulses in EXEC.
  - B.LT: taken, pc_sel_branch=1.
  - LDUR: 5 cycles; STUR: 4 cycles.
  - instr_count=4.
- LDUR with dmem_ready delayed 3 cycles: dmem_re is high for exactly 4 cycles, rf_we goes high 1 cycle later, total 8 cycles.
- CBZ with rt_zero=0 then 1: pc_sel_branch is 0 then 1, with pc_en=1 in EXEC each time.
- opcode=11111111111: trap=1 and trap_cause=01 from the cycle after DECODE; all enables stay 0 for 20 cycles; instr_count does not change.
- imem_ready held at 0 with MEM_TIMEOUT=4: trap cause 10 after the 4th wait cycle. A second run with imem_ready arriving on the timeout cycle proceeds normally.
- reset asserted in the MEM state of a STUR: dmem_we drops on that cycle, no instr_done, and FETCH with imem_req=1 follows the release of reset.
